// File: rtl/cr_prefix_obc_gen.sv
// Prefix-engine output controller: forwards the TLV stream to the user output FIFO and
// inserts PHD/PFD prefix words after each user FRMD TLV, stamping prefix errors into the FTR.
module cr_prefix_obc_gen #(
  parameter int DATA_W = 64,
  parameter int PNUM_W = 6,
  parameter int N_PHD  = 1,
  parameter int N_PFD  = 128,
  parameter int PF_TMO = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_empty,
  output logic              in_rd,
  input  logic              in_sot,
  input  logic              in_eot,
  input  logic [4:0]        in_type,
  input  logic [DATA_W-1:0] in_data,
  input  logic              pf_empty,
  input  logic [PNUM_W+8:0] pf_data,
  output logic              pf_ren,
  input  logic              out_full,
  input  logic              out_afull,
  output logic              out_wr,
  output logic              out_sot,
  output logic              out_eot,
  output logic              out_insert,
  output logic [4:0]        out_type,
  output logic [DATA_W-1:0] out_data,
  output logic              stat_pf_used,
  output logic [PNUM_W-1:0] stat_pnum,
  output logic              stat_pf_tmo
);

  localparam logic [4:0] TLV_CMD            = 5'd1;
  localparam logic [4:0] TLV_PHD            = 5'd3;
  localparam logic [4:0] TLV_PFD            = 5'd4;
  localparam logic [4:0] TLV_FTR            = 5'd6;
  localparam logic [4:0] TLV_FRMD_USER_NULL = 5'd7;
  localparam logic [4:0] TLV_FRMD_USER_PI16 = 5'd8;
  localparam logic [4:0] TLV_FRMD_USER_PI64 = 5'd9;
  localparam logic [4:0] TLV_FRMD_USER_VM   = 5'd10;
  localparam int TMR_W = (PF_TMO > 0) ? $clog2(PF_TMO + 1) : 1;

  typedef enum logic [1:0] {ST_PASS, ST_WAIT_PF, ST_INS_PHD, ST_INS_PFD} state_e;
  typedef enum logic [1:0] {MODE_NONE = 2'd0, MODE_PFD = 2'd1, MODE_PHD_PFD = 2'd2} mode_e;

  state_e              state;
  mode_e               mode;
  logic [PNUM_W-1:0]   user_pnum;
  logic                entry_valid;
  logic                entry_err;
  logic [7:0]          entry_code;
  logic [PNUM_W-1:0]   entry_pnum;
  logic                insert;
  logic [PNUM_W-1:0]   ins_pnum;
  logic                err_flag;
  logic [7:0]          err_code;
  logic [31:0]         frame_num;
  logic [7:0]          cnt;
  logic [TMR_W-1:0]    timer;

  logic                stall, is_frmd, frmd_sot, ftr_eot;
  logic                sot_ins, sot_wait, sot_consume, ins_now, consume;
  logic                ins_first, ins_last;
  logic [PNUM_W-1:0]   entry_pnum_eff, sot_pnum;
  logic [DATA_W-1:0]   pass_data, ins_hdr;

  assign stall = out_full | (out_afull & out_wr) | (state != ST_PASS);
  // NOTE: both pops are gated by rst_n so no FIFO word is popped and lost while held in reset.
  assign in_rd  = rst_n & ~in_empty & ~stall;
  assign pf_ren = rst_n & ~pf_empty & ~entry_valid;

  assign is_frmd  = (in_type == TLV_FRMD_USER_NULL) || (in_type == TLV_FRMD_USER_PI16) ||
                    (in_type == TLV_FRMD_USER_PI64) || (in_type == TLV_FRMD_USER_VM);
  assign frmd_sot = in_rd & is_frmd & in_sot;
  assign ftr_eot  = (in_type == TLV_FTR) & in_eot;

  // An errored entry is treated as prefix number 0, i.e. no insertion.
  assign entry_pnum_eff = entry_err ? '0 : entry_pnum;
  assign ins_now        = frmd_sot ? sot_ins : insert;
  assign consume        = (frmd_sot & sot_consume) | ((state == ST_WAIT_PF) & entry_valid);
  assign ins_first      = (cnt == ((state == ST_INS_PHD) ? 8'(N_PHD) : 8'(N_PFD)));
  assign ins_last       = (cnt == 8'd1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sot_ins     = 1'b0;
    sot_pnum    = '0;
    sot_wait    = 1'b0;
    sot_consume = 1'b0;
    if (mode != MODE_NONE) begin
      if (user_pnum != '0) begin
        sot_ins  = 1'b1;
        sot_pnum = user_pnum;
      end else if (entry_valid) begin
        sot_consume = 1'b1;
        sot_ins     = (entry_pnum_eff != '0);
        sot_pnum    = entry_pnum_eff;
      end else begin
        sot_wait = 1'b1;
      end
    end

    pass_data = in_data;
    if (ftr_eot && (in_data[7:0] == 8'h00) && err_flag) begin
      pass_data[7:0]  = err_code;
      pass_data[39:8] = frame_num;
    end

    // Header layout: pnum in [PNUM_W+7:8], length in [31:16].
    ins_hdr                = '0;
    ins_hdr[PNUM_W+7:8]    = ins_pnum;
    ins_hdr[31:16]         = (state == ST_INS_PHD) ? 16'(N_PHD * 2) : 16'd0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_PASS;
      mode         <= MODE_NONE;
      user_pnum    <= '0;
      entry_valid  <= 1'b0;
      entry_err    <= 1'b0;
      entry_code   <= '0;
      entry_pnum   <= '0;
      insert       <= 1'b0;
      ins_pnum     <= '0;
      err_flag     <= 1'b0;
      err_code     <= '0;
      frame_num    <= '0;
      cnt          <= '0;
      timer        <= '0;
      out_wr       <= 1'b0;
      out_sot      <= 1'b0;
      out_eot      <= 1'b0;
      out_insert   <= 1'b0;
      out_type     <= '0;
      out_data     <= '0;
      stat_pf_used <= 1'b0;
      stat_pnum    <= '0;
      stat_pf_tmo  <= 1'b0;
    end else begin
      out_wr       <= 1'b0;
      stat_pf_used <= 1'b0;
      stat_pf_tmo  <= 1'b0;

      if (consume) begin
        entry_valid  <= 1'b0;
        stat_pf_used <= 1'b1;
        stat_pnum    <= entry_pnum_eff;
      end else if (pf_ren) begin
        entry_valid                         <= 1'b1;
        {entry_err, entry_code, entry_pnum} <= pf_data;
      end

      case (state)
        ST_PASS: if (in_rd) begin
          out_wr     <= (in_type != TLV_CMD);
          out_sot    <= in_sot;
          out_eot    <= in_eot;
          out_type   <= in_type;
          out_data   <= pass_data;
          out_insert <= is_frmd & in_eot & ins_now;
          if ((in_type == TLV_CMD) && in_eot) begin
            mode      <= (in_data[9:8] == 2'd3) ? MODE_NONE : mode_e'(in_data[9:8]);
            user_pnum <= in_data[PNUM_W-1:0];
          end
          if (frmd_sot) begin
            frame_num <= in_data[39:8];
            insert    <= sot_ins;
            ins_pnum  <= sot_pnum;
            err_flag  <= sot_consume & entry_err;
            err_code  <= entry_code;
          end
          if (frmd_sot && sot_wait) begin
            state <= ST_WAIT_PF;
            timer <= '0;
          end else if (is_frmd && in_eot && ins_now) begin
            state <= (mode == MODE_PHD_PFD) ? ST_INS_PHD : ST_INS_PFD;
            cnt   <= (mode == MODE_PHD_PFD) ? 8'(N_PHD) : 8'(N_PFD);
          end
        end

        ST_WAIT_PF: begin
          if (entry_valid) begin
            insert   <= (entry_pnum_eff != '0);
            ins_pnum <= entry_pnum_eff;
            err_flag <= entry_err;
            err_code <= entry_code;
            state    <= ST_PASS;
          end else if ((PF_TMO != 0) && (timer == TMR_W'(PF_TMO - 1))) begin
            insert      <= 1'b0;
            err_flag    <= 1'b1;
            err_code    <= 8'hFF;
            stat_pf_tmo <= 1'b1;
            state       <= ST_PASS;
          end
          if (timer != '1) timer <= timer + 1'b1;
        end

        ST_INS_PHD, ST_INS_PFD: if (!out_full) begin
          out_wr     <= 1'b1;
          out_sot    <= ins_first;
          out_eot    <= ins_last;
          out_insert <= 1'b0;
          out_type   <= (state == ST_INS_PHD) ? TLV_PHD : TLV_PFD;
          out_data   <= ins_first ? ins_hdr : '0;
          if (ins_last) begin
            if (state == ST_INS_PHD) begin
              state <= ST_INS_PFD;
              cnt   <= 8'(N_PFD);
            end else begin
              state <= ST_PASS;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        default: state <= ST_PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_prefix_obc_gen.sv
// Self-checking bench for cr_prefix_obc_gen: table of frame scenarios with expected output
// streams, plus hand sequences for reset state and reset in the middle of an insertion.
module tb_cr_prefix_obc_gen;

  localparam int DW = 64, PW = 6, NPHD = 1, NPFD = 128, TMO = 16;
  localparam logic [4:0] TLV_CMD = 5'd1, TLV_PHD = 5'd3, TLV_PFD = 5'd4, TLV_FTR = 5'd6;
  localparam logic [4:0] F_NULL = 5'd7, F_PI16 = 5'd8, F_PI64 = 5'd9, F_VM = 5'd10;

  logic          clk, rst_n;
  logic          in_empty, in_rd, in_sot, in_eot;
  logic [4:0]    in_type;
  logic [DW-1:0] in_data;
  logic          pf_empty, pf_ren;
  logic [PW+8:0] pf_data;
  logic          out_full, out_afull, out_wr, out_sot, out_eot, out_insert;
  logic [4:0]    out_type;
  logic [DW-1:0] out_data;
  logic          stat_pf_used, stat_pf_tmo;
  logic [PW-1:0] stat_pnum;

  cr_prefix_obc_gen #(.DATA_W(DW), .PNUM_W(PW), .N_PHD(NPHD), .N_PFD(NPFD), .PF_TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_empty(in_empty), .in_rd(in_rd), .in_sot(in_sot), .in_eot(in_eot),
    .in_type(in_type), .in_data(in_data),
    .pf_empty(pf_empty), .pf_data(pf_data), .pf_ren(pf_ren),
    .out_full(out_full), .out_afull(out_afull), .out_wr(out_wr), .out_sot(out_sot),
    .out_eot(out_eot), .out_insert(out_insert), .out_type(out_type), .out_data(out_data),
    .stat_pf_used(stat_pf_used), .stat_pnum(stat_pnum), .stat_pf_tmo(stat_pf_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic sot; logic eot; logic [4:0] typ; logic [63:0] data;} in_word_t;
  typedef struct packed {logic sot; logic eot; logic ins; logic [4:0] typ; logic [63:0] data;} word_t;
  typedef struct {
    logic [1:0] mode; logic [5:0] upnum; logic pf_v; logic [PW+8:0] pf; logic [4:0] ftype;
    logic [31:0] fnum; logic [7:0] ftr_code; logic full_tgl;
    logic exp_ins; logic [5:0] exp_pnum; logic exp_used; logic [5:0] exp_used_pnum;
    logic exp_tmo; logic exp_stamp; logic [7:0] exp_code;
  } scn_t;

  in_word_t      inq[$];
  logic [PW+8:0] pfq[$];
  word_t         outq[$];
  scn_t          scn[9];
  int            n_chk = 0, n_err = 0, cyc = 0;
  int            n_used, n_tmo, sot_cyc, tmo_cyc;
  logic [5:0]    last_pnum;
  logic          full_tgl;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic f_is_frmd(input logic [4:0] t);
    return (t == F_NULL) || (t == F_PI16) || (t == F_PI64) || (t == F_VM);
  endfunction

  function automatic logic [63:0] hdr(input logic [5:0] pn, input logic [15:0] len);
    logic [63:0] h;
    h        = '0;
    h[13:8]  = pn;
    h[31:16] = len;
    return h;
  endfunction

  task automatic drive();
    in_empty = (inq.size() == 0);
    if (!in_empty) {in_sot, in_eot, in_type, in_data} = inq[0];
    else {in_sot, in_eot, in_type, in_data} = '0;
    pf_empty  = (pfq.size() == 0);
    pf_data   = pf_empty ? '0 : pfq[0];
    out_full  = full_tgl && ((cyc / 3) % 2 == 1);
    out_afull = full_tgl && (cyc % 3 == 0);
  endtask

  task automatic tick();
    logic pop, ppop;
    @(negedge clk);
    pop  = in_rd;
    ppop = pf_ren;
    @(posedge clk);
    #1;
    cyc++;
    if (pop && inq.size() != 0) begin
      if (f_is_frmd(inq[0].typ) && inq[0].sot) sot_cyc = cyc;
      void'(inq.pop_front());
    end
    if (ppop && pfq.size() != 0) void'(pfq.pop_front());
    if (out_wr) outq.push_back({out_sot, out_eot, out_insert, out_type, out_data});
    if (stat_pf_used) begin n_used++; last_pnum = stat_pnum; end
    if (stat_pf_tmo) begin n_tmo++; tmo_cyc = cyc; end
    drive();
  endtask

  task automatic push_frame(input scn_t s, input int id);
    inq.push_back({1'b1, 1'b1, TLV_CMD, 64'({s.mode, 2'b00, s.upnum})});
    inq.push_back({1'b1, 1'b0, s.ftype, {24'h0, s.fnum, 8'h00}});
    inq.push_back({1'b0, 1'b0, s.ftype, 64'h1111_2222_3333_4444 + 64'(id)});
    inq.push_back({1'b0, 1'b1, s.ftype, 64'hDEAD_BEEF_0000_0000 | 64'(id)});
    inq.push_back({1'b1, 1'b1, TLV_FTR, {24'hC0FFEE, 32'h0, s.ftr_code}});
  endtask

  task automatic run_frame(input int id, input scn_t s);
    word_t exp_q[$];
    int    n;
    if (s.pf_v) pfq.push_back(s.pf);
    full_tgl = s.full_tgl;
    drive();
    repeat (3) tick();
    outq.delete();
    n_used = 0; n_tmo = 0; last_pnum = '0; sot_cyc = 0; tmo_cyc = 0;
    push_frame(s, id);
    exp_q.push_back({1'b1, 1'b0, 1'b0, s.ftype, {24'h0, s.fnum, 8'h00}});
    exp_q.push_back({1'b0, 1'b0, 1'b0, s.ftype, 64'h1111_2222_3333_4444 + 64'(id)});
    exp_q.push_back({1'b0, 1'b1, s.exp_ins, s.ftype, 64'hDEAD_BEEF_0000_0000 | 64'(id)});
    if (s.exp_ins) begin
      if (s.mode == 2'd2)
        for (int k = 0; k < NPHD; k++)
          exp_q.push_back({k == 0, k == NPHD - 1, 1'b0, TLV_PHD,
                           (k == 0) ? hdr(s.exp_pnum, 16'(NPHD * 2)) : 64'h0});
      for (int k = 0; k < NPFD; k++)
        exp_q.push_back({k == 0, k == NPFD - 1, 1'b0, TLV_PFD,
                         (k == 0) ? hdr(s.exp_pnum, 16'd0) : 64'h0});
    end
    exp_q.push_back({1'b1, 1'b1, 1'b0, TLV_FTR,
                     {24'hC0FFEE, s.exp_stamp ? s.fnum : 32'h0, s.exp_code}});
    drive();
    n = 0;
    while ((inq.size() != 0 || outq.size() < exp_q.size()) && n < 3000) begin
      tick();
      n++;
    end
    repeat (6) tick();
    check($sformatf("s%0d_drained", id), n < 3000, 1);
    check($sformatf("s%0d_count", id), outq.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < outq.size(); k++)
      check($sformatf("s%0d_word%0d", id, k), outq[k], exp_q[k]);
    check($sformatf("s%0d_used", id), n_used, s.exp_used);
    if (s.exp_used) check($sformatf("s%0d_stat_pnum", id), last_pnum, s.exp_used_pnum);
    check($sformatf("s%0d_tmo", id), n_tmo, s.exp_tmo);
    if (s.exp_tmo) check($sformatf("s%0d_tmo_lat", id), tmo_cyc - sot_cyc, TMO);
    full_tgl = 1'b0;
  endtask

  function automatic logic [82:0] all_outs();
    return {in_rd, pf_ren, out_wr, out_sot, out_eot, out_insert, out_type, out_data,
            stat_pf_used, stat_pnum, stat_pf_tmo};
  endfunction

  initial begin
    int n;
    //          mode  up     pfv  pf                    ftype   fnum           ftr    tgl   ins   pnum   used  upn    tmo   stamp  code
    scn[0] = '{2'd0, 6'd0,  1'b0, '0,                  F_NULL, 32'h0000_00A1, 8'h00, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 1'b0, 1'b0, 8'h00};
    scn[1] = '{2'd2, 6'd0,  1'b1, {1'b0, 8'h00, 6'd5}, F_PI16, 32'h1234_5678, 8'h00, 1'b0, 1'b1, 6'd5,  1'b1, 6'd5, 1'b0, 1'b0, 8'h00};
    scn[2] = '{2'd1, 6'd9,  1'b0, '0,                  F_PI64, 32'hA5A5_0002, 8'h00, 1'b0, 1'b1, 6'd9,  1'b0, 6'd0, 1'b0, 1'b0, 8'h00};
    scn[3] = '{2'd1, 6'd0,  1'b0, '0,                  F_VM,   32'hFEED_0003, 8'h00, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 1'b1, 1'b1, 8'hFF};
    scn[4] = '{2'd1, 6'd0,  1'b1, {1'b1, 8'h23, 6'd7}, F_NULL, 32'h0BAD_0004, 8'h00, 1'b0, 1'b0, 6'd0,  1'b1, 6'd0, 1'b0, 1'b1, 8'h23};
    scn[5] = '{2'd1, 6'd0,  1'b1, {1'b1, 8'h23, 6'd7}, F_NULL, 32'h0BAD_0005, 8'h11, 1'b0, 1'b0, 6'd0,  1'b1, 6'd0, 1'b0, 1'b0, 8'h11};
    scn[6] = '{2'd2, 6'd0,  1'b1, {1'b0, 8'h00, 6'd0}, F_PI16, 32'h0000_0006, 8'h00, 1'b0, 1'b0, 6'd0,  1'b1, 6'd0, 1'b0, 1'b0, 8'h00};
    scn[7] = '{2'd2, 6'd63, 1'b0, '0,                  F_PI64, 32'h0000_0007, 8'h5A, 1'b0, 1'b1, 6'd63, 1'b0, 6'd0, 1'b0, 1'b0, 8'h5A};
    scn[8] = '{2'd1, 6'd12, 1'b0, '0,                  F_VM,   32'h0000_0008, 8'h00, 1'b1, 1'b1, 6'd12, 1'b0, 6'd0, 1'b0, 1'b0, 8'h00};

    // Reset state, with both FIFOs non-empty so any ungated pop would show.
    rst_n    = 1'b0;
    full_tgl = 1'b0;
    pfq.push_back({1'b0, 8'h00, 6'd1});
    inq.push_back({1'b1, 1'b1, TLV_CMD, 64'h200});
    drive();
    repeat (3) tick();
    check("rst_outputs", all_outs(), '0);
    inq.delete();
    pfq.delete();
    drive();
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 9; i++) run_frame(i, scn[i]);

    // Reset asserted partway through the PFD insertion.
    outq.delete();
    push_frame('{2'd1, 6'd3, 1'b0, '0, F_NULL, 32'h0000_0009, 8'h00, 1'b0,
                 1'b1, 6'd3, 1'b0, 6'd0, 1'b0, 1'b0, 8'h00}, 9);
    drive();
    n = 0;
    while (outq.size() < 12 && n < 500) begin
      tick();
      n++;
    end
    check("rst_mid_reached", outq.size() >= 12, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", all_outs(), '0);
    inq.delete();
    pfq.delete();
    drive();
    repeat (3) tick();
    rst_n = 1'b1;
    outq.delete();
    repeat (5) tick();
    check("rst_mid_idle", outq.size(), 0);
    run_frame(10, scn[0]);
    run_frame(11, scn[1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
